cnu_serial_min_tracker: RTL and testbench
=========================================

Name: cnu_serial_min_tracker

Overview:
- Serial check-node magnitude tracker for the layered min-sum LDPC decoder.
- Accepts one variable-to-check message per cycle over a framed row of programmable degree.
- Produces the true first minimum, true second minimum, first-minimum index and sign parity.
- Successor to the fixed 8-input combinational min tree: it adds arbitrary row degree up to MAX_DEG, an exact min2 instead of the min1+1 approximation, sign handling and a valid/ready output.

Parameters:
- MAG_W, 5: magnitude width in bits (unsigned).
- MAX_DEG, 19: maximum row degree (messages per frame); must be at least 2.
- IDX_W, 5: index width; must satisfy 2^IDX_W >= MAX_DEG.
- OFFSET, 1: offset subtracted when OFFSET_MS_EN is defined.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: an input message is present.
- in_ready, output, 1: the block accepts the message this cycle.
- in_first, input, 1: first message of a row.
- in_last, input, 1: last message of a row.
- in_sign, input, 1: message sign (1 = negative).
- in_mag, input, MAG_W: message magnitude.
- out_valid, output, 1: result held.
- out_ready, input, 1: downstream accepts the result.
- out_min1, output, MAG_W: smallest magnitude.
- out_min2, output, MAG_W: second-smallest magnitude.
- out_idx, output, IDX_W: position of min1 within the row (0-based).
- out_sign, output, 1: XOR of all signs in the row.
- out_deg, output, IDX_W+1: number of messages accumulated.
- out_err, output, 1: the row was malformed (see below).

Behaviour:
- Reset: ST_IDLE, out_valid=0, out_min1=0, out_min2=0, out_idx=0, out_sign=0, out_deg=0, out_err=0, internal count=0. A reset mid-row discards the partial row. A reset while out_valid=1 drops the held result.
- in_ready = !(out_valid && !out_ready). A beat is accepted when in_valid && in_ready.
- States:
  - ST_IDLE: accepted beats without in_first are dropped. A beat with in_first goes to ST_ACC and initialises min1=in_mag, min2=all-ones (2^MAG_W-1), idx=0, sign=in_sign, cnt=1.
  - ST_ACC, per accepted beat at position cnt:
    - if in_mag < min1: min2<=min1, min1<=in_mag, idx<=cnt.
    - else if in_mag < min2: min2<=in_mag.
    - sign ^= in_sign; cnt++.
  - Comparisons are strict, so on ties the lowest index keeps min1, and an equal later value becomes min2 (e.g. 3,3 gives min1=3, min2=3, idx=0).
- Close: an accepted beat with in_last (including a beat that has both in_first and in_last, i.e. degree 1) folds that beat in, then registers the result. out_valid=1 on the next cycle, giving 1-cycle latency. Return to ST_IDLE.
- Back-to-back rows: the next row's in_first beat may be accepted in the cycle right after in_last if in_ready=1. Zero bubbles are required when out_ready is held high.
- Degree 1: out_min2 = all-ones.
- Overflow: if cnt reaches MAX_DEG without in_last, the beat at position MAX_DEG-1 force-closes the row with out_err=1. Further beats up to and including in_last are dropped in ST_IDLE.
- in_first during ST_ACC: the partial row is discarded and the accumulator restarts from this beat. The next emitted result carries out_err=1.
- Output hold: all out_* fields stay stable while out_valid && !out_ready. out_valid deasserts the cycle after the handshake unless a new result closes in that same cycle, in which case it stays high with the new data.
- out_deg saturates at MAX_DEG.

Optional Feature:
- Macro: OFFSET_MS_EN.
- Defined: out_min1 and out_min2 are each reduced by OFFSET, saturating at 0, in the output register stage. Latency is unchanged. Index, sign and degree are unaffected. The all-ones min2 sentinel is also reduced.
- Undefined: raw normalised-free min-sum values are output and the OFFSET parameter is ignored.

Test Plan:
- Row mags 9,4,7,4,12 (first/last framed), signs 1,0,1,1,0, out_ready=1 -> next cycle out_min1=4, out_min2=4, out_idx=1, out_sign=1, out_deg=5, out_err=0.
- Degree-1 row with mag 6 (in_first and in_last together) -> min1=6, min2=31, idx=0, deg=1.
- Two 4-beat rows back-to-back with out_ready=1 -> two results on consecutive frame boundaries with no in_ready drop. Then hold out_ready=0 -> in_ready=0 and the result is stable until out_ready=1.
- 20 beats without in_last (MAX_DEG=19) -> result after the 19th beat with out_err=1, out_deg=19. The 20th beat is dropped and the following framed row is processed normally.
- in_first re-asserted mid-row after 3 beats, then a 2-beat row 5,2 -> min1=2, min2=5, idx=1, deg=2, out_err=1.
- With OFFSET_MS_EN and OFFSET=1: row 0,3 -> min1=0 (saturated), min2=2. Reset asserted mid-row -> all outputs 0 and the next row is unaffected.

Source files
------------

// File: rtl/cnu_serial_min_tracker.sv
// Serial min1/min2/index/sign-parity tracker for a layered min-sum LDPC check node.
// Define OFFSET_MS_EN to apply offset min-sum correction to the output magnitudes.
module cnu_serial_min_tracker #(
  parameter int MAG_W   = 5,
  parameter int MAX_DEG = 19,
  parameter int IDX_W   = 5,
  parameter int OFFSET  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sign,
  input  logic [MAG_W-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_min1,
  output logic [MAG_W-1:0] out_min2,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_sign,
  output logic [IDX_W:0]   out_deg,
  output logic             out_err
);

  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_ACC    = 1'b1;
  localparam logic [MAG_W-1:0] MAG_ONES  = '1;
  localparam logic [IDX_W:0]   DEG_LIMIT = (IDX_W+1)'(MAX_DEG);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);

  if (MAX_DEG < 2) begin : g_chk_deg
    $error("MAX_DEG must be at least 2");
  end
  if ((1 << IDX_W) < MAX_DEG) begin : g_chk_idx
    $error("IDX_W too narrow for MAX_DEG");
  end
  if (OFFSET < 0) begin : g_chk_off
    $error("OFFSET must be non-negative");
  end

  function automatic logic [MAG_W-1:0] out_mag(input logic [MAG_W-1:0] mag);
`ifdef OFFSET_MS_EN
    int diff;
    diff = int'(mag) - OFFSET;
    return (diff > 0) ? MAG_W'(diff) : '0;
`else
    return mag;
`endif
  endfunction

  logic [0:0]       state_p0;
  logic [MAG_W-1:0] min1_p0;
  logic [MAG_W-1:0] min2_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             sign_p0;
  logic             err_p0;
  logic [IDX_W:0]   cnt_p0;

  logic             vld_p1;
  logic [MAG_W-1:0] min1_p1;
  logic [MAG_W-1:0] min2_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             sign_p1;
  logic [IDX_W:0]   deg_p1;
  logic             err_p1;

  logic             accept;
  logic             start;
  logic             fold;
  logic             take;
  logic             close;
  logic             overflow;
  logic [MAG_W-1:0] n_min1;
  logic [MAG_W-1:0] n_min2;
  logic [IDX_W-1:0] n_idx;
  logic             n_sign;
  logic             n_err;
  logic [IDX_W:0]   n_cnt;

  assign in_ready = !(vld_p1 && !out_ready);

  // Stage p0: fold the accepted beat into the running row accumulator
  always_comb begin
    accept   = in_valid && in_ready;
    start    = accept && in_first;
    fold     = accept && !in_first && (state_p0 == ST_ACC);
    take     = start || fold;
    n_min1   = min1_p0;
    n_min2   = min2_p0;
    n_idx    = idx_p0;
    n_sign   = sign_p0;
    n_cnt    = cnt_p0;
    n_err    = err_p0;
    if (start) begin
      n_min1 = in_mag;
      n_min2 = MAG_ONES;
      n_idx  = '0;
      n_sign = in_sign;
      n_cnt  = CNT_ONE;
      // A first beat arriving mid-row marks the restarted row as malformed
      n_err  = (state_p0 == ST_ACC);
    end else if (fold) begin
      if (in_mag < min1_p0) begin
        n_min2 = min1_p0;
        n_min1 = in_mag;
        n_idx  = cnt_p0[IDX_W-1:0];
      end else if (in_mag < min2_p0) begin
        n_min2 = in_mag;
      end
      n_sign = sign_p0 ^ in_sign;
      n_cnt  = cnt_p0 + CNT_ONE;
    end
    overflow = take && !in_last && (n_cnt >= DEG_LIMIT);
    close    = take && (in_last || (n_cnt >= DEG_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (take) begin
      min1_p0 <= n_min1;
      min2_p0 <= n_min2;
      idx_p0  <= n_idx;
      sign_p0 <= n_sign;
    end
  end

  // Stage p1: registered result, held until the downstream handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      cnt_p0   <= '0;
      err_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      min1_p1  <= '0;
      min2_p1  <= '0;
      idx_p1   <= '0;
      sign_p1  <= 1'b0;
      deg_p1   <= '0;
      err_p1   <= 1'b0;
    end else begin
      if (take) begin
        state_p0 <= close ? ST_IDLE : ST_ACC;
        cnt_p0   <= close ? '0 : n_cnt;
        err_p0   <= close ? 1'b0 : n_err;
      end
      if (close) begin
        vld_p1  <= 1'b1;
        min1_p1 <= out_mag(n_min1);
        min2_p1 <= out_mag(n_min2);
        idx_p1  <= n_idx;
        sign_p1 <= n_sign;
        deg_p1  <= n_cnt;
        err_p1  <= n_err || overflow;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_min1  = min1_p1;
  assign out_min2  = min2_p1;
  assign out_idx   = idx_p1;
  assign out_sign  = sign_p1;
  assign out_deg   = deg_p1;
  assign out_err   = err_p1;

endmodule

// File: tb/tb_cnu_serial_min_tracker.sv
// Self-checking bench for cnu_serial_min_tracker: directed and random rows against a queue-based row model.
module tb_cnu_serial_min_tracker;
  localparam int MAG_W   = 5;
  localparam int MAX_DEG = 19;
  localparam int IDX_W   = 5;
  localparam int OFFSET  = 1;
  localparam int ONES    = (1 << MAG_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic             in_sign;
  logic [MAG_W-1:0] in_mag;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W-1:0] out_min1;
  logic [MAG_W-1:0] out_min2;
  logic [IDX_W-1:0] out_idx;
  logic             out_sign;
  logic [IDX_W:0]   out_deg;
  logic             out_err;

  int total = 0;
  int bad   = 0;
  int row_m[$];
  bit row_s[$];
  bit chk_rdy = 1'b0;

  cnu_serial_min_tracker #(
    .MAG_W(MAG_W), .MAX_DEG(MAX_DEG), .IDX_W(IDX_W), .OFFSET(OFFSET)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_sign(in_sign), .in_mag(in_mag),
    .out_valid(out_valid), .out_ready(out_ready), .out_min1(out_min1),
    .out_min2(out_min2), .out_idx(out_idx), .out_sign(out_sign),
    .out_deg(out_deg), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input bit f, input bit l, input bit s, input int m);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_sign  = s;
    in_mag   = MAG_W'(m);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_sign  = 1'b0;
    in_mag   = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 0);
    chk({tag, ".min1"},  32'(out_min1), 0);
    chk({tag, ".min2"},  32'(out_min2), 0);
    chk({tag, ".idx"},   32'(out_idx), 0);
    chk({tag, ".sign"},  32'(out_sign), 0);
    chk({tag, ".deg"},   32'(out_deg), 0);
    chk({tag, ".err"},   32'(out_err), 0);
  endtask

  // Expected result derived from the whole row: smallest value, its first position,
  // smallest of the remaining values, XOR of all signs.
  task automatic check_row(input string tag, input bit exp_err);
    int q[$];
    int rest[$];
    int mn;
    int mn2;
    int id;
    bit sg;
    q  = row_m.min();
    mn = q[0];
    q  = row_m.find_first_index(x) with (x == mn);
    id = q[0];
    rest = row_m;
    rest.delete(id);
    if (rest.size() == 0) begin
      mn2 = ONES;
    end else begin
      q   = rest.min();
      mn2 = q[0];
    end
    sg = 1'b0;
    foreach (row_s[i]) sg ^= row_s[i];
`ifdef OFFSET_MS_EN
    mn  = (mn > OFFSET) ? mn - OFFSET : 0;
    mn2 = (mn2 > OFFSET) ? mn2 - OFFSET : 0;
`endif
    chk({tag, ".valid"}, 32'(out_valid), 1);
    chk({tag, ".min1"},  32'(out_min1), mn);
    chk({tag, ".min2"},  32'(out_min2), mn2);
    chk({tag, ".idx"},   32'(out_idx), id);
    chk({tag, ".sign"},  32'(out_sign), 32'(sg));
    chk({tag, ".deg"},   32'(out_deg), row_m.size());
    chk({tag, ".err"},   32'(out_err), 32'(exp_err));
  endtask

  task automatic run_row(input string tag, input bit exp_err);
    for (int i = 0; i < row_m.size(); i++) begin
      beat(i == 0, i == row_m.size() - 1, row_s[i], row_m[i]);
      if (chk_rdy) chk({tag, ".in_ready"}, 32'(in_ready), 1);
    end
    check_row(tag, exp_err);
  endtask

  task automatic rand_row(input int d, input int hi);
    row_m.delete();
    row_s.delete();
    for (int i = 0; i < d; i++) begin
      row_m.push_back(int'($urandom_range(hi, 0)));
      row_s.push_back(1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    int m;
    bit s;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_sign   = 1'b0;
    in_mag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset.in_ready", 32'(in_ready), 1);
    rst = 1'b0;

    row_m = '{9, 4, 7, 4, 12};
    row_s = '{1, 0, 1, 1, 0};
    run_row("row5", 1'b0);
`ifndef OFFSET_MS_EN
    chk("row5.min1_const", 32'(out_min1), 4);
    chk("row5.min2_const", 32'(out_min2), 4);
    chk("row5.idx_const",  32'(out_idx), 1);
`endif
    idle(1);
    chk("row5.valid_drop", 32'(out_valid), 0);

    row_m = '{6};
    row_s = '{0};
    run_row("deg1", 1'b0);
    idle(1);

    row_m = '{3, 3};
    row_s = '{0, 1};
    run_row("tie", 1'b0);
    idle(1);

    chk_rdy = 1'b1;
    rand_row(4, 31);
    run_row("b2b_a", 1'b0);
    rand_row(4, 31);
    run_row("b2b_b", 1'b0);
    chk_rdy = 1'b0;

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_first  = 1'b1;
    in_last   = 1'b1;
    in_sign   = 1'b1;
    in_mag    = MAG_W'(2);
    #1;
    chk("hold.in_ready", 32'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check_row("hold", 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    row_m = '{2};
    row_s = '{1};
    check_row("hold_release", 1'b0);
    idle(1);
    chk("release.valid_drop", 32'(out_valid), 0);

    row_m.delete();
    row_s.delete();
    for (int i = 0; i < MAX_DEG; i++) begin
      m = int'($urandom_range(31, 0));
      s = 1'($urandom_range(1, 0));
      row_m.push_back(m);
      row_s.push_back(s);
      beat(i == 0, 1'b0, s, m);
    end
    check_row("ovf", 1'b1);
    beat(1'b0, 1'b0, 1'b1, 0);
    chk("ovf.drop20", 32'(out_valid), 0);
    idle(1);
    rand_row(5, 31);
    run_row("post_ovf", 1'b0);
    idle(1);

    rand_row(MAX_DEG, 31);
    run_row("full_deg", 1'b0);
    idle(1);

    beat(1'b1, 1'b0, 1'b0, 9);
    beat(1'b0, 1'b0, 1'b1, 7);
    beat(1'b0, 1'b0, 1'b0, 8);
    row_m = '{5, 2};
    row_s = '{1, 0};
    run_row("restart", 1'b1);
`ifndef OFFSET_MS_EN
    chk("restart.min1_const", 32'(out_min1), 2);
    chk("restart.min2_const", 32'(out_min2), 5);
`endif
    idle(1);
    rand_row(3, 31);
    run_row("post_restart", 1'b0);
    idle(1);

    beat(1'b1, 1'b0, 1'b1, 4);
    beat(1'b0, 1'b0, 1'b0, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_zero("rst_mid");
    rand_row(3, 31);
    run_row("post_rst", 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_held.valid", 32'(out_valid), 0);
    rand_row(2, 31);
    run_row("post_rst2", 1'b0);
    idle(1);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(3, 0) == 0) beat(1'b0, 1'($urandom_range(1, 0)), 1'b1, 0);
      rand_row(int'($urandom_range(MAX_DEG, 1)), (r % 2 == 1) ? 31 : 3);
      run_row("rand", 1'b0);
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(2, 1)));
    end
    idle(1);
    chk("final.valid", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
